// File: rtl/result_serializer.sv
// Output stage of the MLP accelerator: gathers 2-row result slices into a
// 16x16 matrix, then streams it out two elements per 32-bit word.
module result_serializer #(
  parameter int DATA_W         = 16,
  parameter int COLS           = 16,
  parameter int ROWS_PER_ROUND = 2,
  parameter int ROUNDS         = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          round_valid_i,
  input  logic [3:0]                                    round_number_i,
  input  logic [ROWS_PER_ROUND-1:0][COLS-1:0][DATA_W-1:0] round_data_i,
  input  logic                                          result_ready_i,
  output logic                                          result_valid_o,
  output logic [2*DATA_W-1:0]                           result_payload_o,
  output logic                                          result_last_o,
  output logic                                          busy_o,
  output logic                                          drop_err_o
);

  localparam int ROWS  = ROUNDS * ROWS_PER_ROUND;
  localparam int WORDS = ROWS * COLS / 2;
  localparam int KW    = $clog2(WORDS);
  localparam int RW    = $clog2(ROWS);
  localparam int PW    = KW - RW;

  typedef enum logic {COLLECT, STREAM} state_t;

  state_t                       state_q;
  logic [COLS-1:0][DATA_W-1:0]  mat_q [ROWS];
  logic [ROUNDS-1:0]            mask_q;
  logic [KW-1:0]                k_q;

  logic              legal;
  logic [2:0]        slot;
  logic              xfer;
  logic              final_xfer;
  logic              accept;
  logic              drop;
  logic [ROUNDS-1:0] mask_set;
  logic [ROUNDS-1:0] mask_next;
  logic [RW-1:0]     rd_row;
  logic [PW-1:0]     rd_pair;

  // Handshake: a word moves on any edge where result_valid_o & result_ready_i;
  // once valid is up it holds, with payload/last stable, until that transfer.
  always_comb begin
    legal      = ~round_number_i[3];
    slot       = round_number_i[2:0];
    xfer       = (state_q == STREAM) & result_ready_i;
    final_xfer = xfer & (k_q == KW'(WORDS - 1));
    // The edge that retires the last word already belongs to the next collection.
    accept     = round_valid_i & legal & ((state_q == COLLECT) | final_xfer);
    drop       = round_valid_i & ~accept;
    mask_set   = accept ? (ROUNDS'(1) << slot) : '0;
    mask_next  = mask_q | mask_set;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mat_q[{slot, 1'b0}] <= round_data_i[0];
      mat_q[{slot, 1'b1}] <= round_data_i[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      mask_q     <= '0;
      k_q        <= '0;
      drop_err_o <= 1'b0;
    end else begin
      if (drop) drop_err_o <= 1'b1;
      case (state_q)
        COLLECT: begin
          if (mask_next == '1) begin
            state_q <= STREAM;
            mask_q  <= '0;
            k_q     <= '0;
          end else begin
            mask_q <= mask_next;
          end
        end
        STREAM: begin
          if (xfer) begin
            k_q <= k_q + KW'(1);
            if (final_xfer) begin
              state_q <= COLLECT;
              mask_q  <= mask_next;
            end
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  always_comb begin
    rd_row           = k_q[KW-1:PW];
    rd_pair          = k_q[PW-1:0];
    busy_o           = (state_q == STREAM);
    result_valid_o   = busy_o;
    result_last_o    = busy_o & (k_q == KW'(WORDS - 1));
    result_payload_o = '0;
    if (busy_o)
      result_payload_o = {mat_q[rd_row][{rd_pair, 1'b1}], mat_q[rd_row][{rd_pair, 1'b0}]};
  end

endmodule
